// File: rtl/ysyx_24090013_pcgen.sv
// PC generator / fetch front end: issues one instruction fetch at a time and hands the
// fetched instruction to decode. Traps and branch redirects may cancel a fetch at any stage.
module ysyx_24090013_pcgen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = 32'h8000_0000,
  parameter int unsigned     STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_inst_q;

  logic            redir;
  logic [XLEN-1:0] redir_raw;
  logic [XLEN-1:0] target;

  // Trap outranks a branch redirect; targets are always word aligned.
  always_comb begin
    redir     = trap_valid | redirect_valid;
    redir_raw = trap_valid ? trap_pc : redirect_pc;
    target    = {redir_raw[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VAL;
      drop_q     <= 1'b0;
      out_pc_q   <= RESET_VAL;
      out_inst_q <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          if (redir) pc_q <= target;
          state_q <= StReq;
        end
        StReq: begin
          if (redir) pc_q <= target;
          if (imem_req_ready) begin
            // Fetch already issued for the stale PC: its response must be dropped.
            drop_q  <= redir;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redir) begin
            pc_q <= target;
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (drop_q) begin
              state_q <= StReq;
            end else begin
              out_pc_q   <= pc_q;
              out_inst_q <= imem_rsp_data;
              state_q    <= StHold;
            end
          end
        end
        StHold: begin
          if (redir) begin
            pc_q    <= target;
            state_q <= StReq;
          end else if (out_ready) begin
            pc_q    <= pc_q + XLEN'(STEP);
            state_q <= StReq;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = pc_q;
    out_valid      = (state_q == StHold);
    out_pc         = out_pc_q;
    out_inst       = out_inst_q;
  end

endmodule

// File: tb/tb_ysyx_24090013_pcgen.sv
// Directed bench for the PC generator: a 1-cycle-latency memory model plus hand-checked
// redirect, trap, stall, wrap and reset sequences.
module tb_ysyx_24090013_pcgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;
  bit auto_mem = 1'b0;

  ysyx_24090013_pcgen dut (
    .clk           (clk),
    .rst           (rst),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; with auto_mem set, a request accepted at this edge answers at the next edge.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    acc = (imem_req_valid === 1'b1) && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic wait_out(input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("out_valid_timeout", {31'b0, found}, 32'd1);
    chk("out_pc", out_pc, pc);
    chk("out_inst", out_inst, mem_word(pc));
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    rst = 1'b1; trap_valid = 1'b0; trap_pc = 32'h0; redirect_valid = 1'b1;
    redirect_pc = 32'h1111_1110; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; out_ready = 1'b1;
    #1;
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_out_pc", out_pc, 32'h8000_0000);
    chk("rst_out_inst", out_inst, 32'h0);

    // Single bubble, then the first fetch at the reset vector.
    rst = 1'b0; redirect_valid = 1'b0; auto_mem = 1'b1;
    step();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    wait_out(32'h8000_0000); step();
    wait_out(32'h8000_0004); step();
    wait_out(32'h8000_0008); step();

    // Decode stall holds the instruction and issues no new fetch.
    out_ready = 1'b0;
    wait_out(32'h8000_000C);
    held_pc = out_pc; held_inst = out_inst;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_out_pc", out_pc, held_pc);
      chk("stall_out_inst", out_inst, held_inst);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end
    out_ready = 1'b1;
    step();

    // Redirect in WAIT before the response: response is later dropped.
    auto_mem = 1'b0; imem_rsp_valid = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    chk("wredir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("wredir_addr", imem_req_addr, 32'h8000_0100);
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    chk("drop_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h8000_0100);
    imem_rsp_valid = 1'b0; auto_mem = 1'b1;
    wait_out(32'h8000_0100); step();

    // Trap beats redirect, applied in REQ while memory is not ready.
    imem_req_ready = 1'b0;
    trap_valid = 1'b1; trap_pc = 32'h8000_0200;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    chk("trap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("trap_req_addr", imem_req_addr, 32'h8000_0200);
    trap_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    wait_out(32'h8000_0200);

    // Redirect in HOLD overrides the sequential step; target gets aligned.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    step();
    chk("hredir_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hredir_req_addr", imem_req_addr, 32'h8000_0100);
    redirect_valid = 1'b0;
    wait_out(32'h8000_0100); step();

    // Redirect in REQ coincident with acceptance: stale response discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    step();
    redirect_valid = 1'b0;
    step();
    chk("rqacc_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rqacc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rqacc_req_addr", imem_req_addr, 32'h8000_0040);
    wait_out(32'h8000_0040); step();

    // PC wraps at the top of the address space.
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    wait_out(32'hFFFF_FFFC); step();
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

    // Reset mid-WAIT (with a redirect pending); the late response is ignored.
    auto_mem = 1'b0; imem_rsp_valid = 1'b0;
    step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
    step();
    chk("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("mrst_out_pc", out_pc, 32'h8000_0000);
    chk("mrst_out_inst", out_inst, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    step();
    chk("late_out_valid", {31'b0, out_valid}, 32'd0);
    chk("late_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("late_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    chk("reqrsp_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reqrsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; auto_mem = 1'b1;
    wait_out(32'h8000_0000); step();

    // Redirect in WAIT coincident with the response: straight back to REQ.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0080;
    step();
    chk("wrsp_out_valid", {31'b0, out_valid}, 32'd0);
    chk("wrsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrsp_req_addr", imem_req_addr, 32'h8000_0080);
    redirect_valid = 1'b0;
    wait_out(32'h8000_0080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24090013_pcgen.md
YSYX_24090013_PCGEN -- requirements
Module: ysyx_24090013_pcgen

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_VAL, default 32'h8000_0000, PC after reset.
REQ-003 SHALL have parameter STEP, default 4, sequential PC increment.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port trap_valid  input  1  trap/exception redirect request.
REQ-007 SHALL have port trap_pc  input  XLEN  trap target.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request from EX.
REQ-009 SHALL have port redirect_pc  input  XLEN  branch/jump target.
REQ-010 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-012 SHALL have port imem_req_addr  output  XLEN  fetch address, equals current PC.
REQ-013 SHALL have port imem_rsp_valid  input  1  fetch data valid.
REQ-014 SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-015 SHALL have port out_valid  output  1  instruction valid to ID.
REQ-016 SHALL have port out_ready  input  1  ID accepts instruction.
REQ-017 SHALL have ports out_pc (output, XLEN) and out_inst (output, 32): PC and instruction presented to ID.

Function
REQ-018 SHALL implement FSM states BOOT, REQ, WAIT, HOLD plus a 1-bit drop flag; all state updates on rising clk only.
REQ-019 BOOT: all handshake outputs low; unconditionally -> REQ next cycle (exactly one bubble after reset).
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-021 WAIT: on imem_rsp_valid with drop=0: latch imem_rsp_data into out_inst, pc into out_pc -> HOLD; with drop=1: discard data, clear drop -> REQ.
REQ-022 HOLD: out_valid=1, out_pc/out_inst stable; on out_ready: pc <= pc + STEP (mod 2^XLEN, wrap silently) -> REQ.
REQ-023 Redirect source SHALL be trap when trap_valid=1, else redirect_pc when redirect_valid=1; trap wins when both high; target low two bits forced to zero.
REQ-024 Redirect in BOOT or REQ without imem_req_ready: pc <= target, state -> REQ; imem_req_addr SHALL follow the new pc next cycle (address change while valid is permitted).
REQ-025 Redirect in REQ with imem_req_ready same cycle: pc <= target, drop <= 1, -> WAIT.
REQ-026 Redirect in WAIT without imem_rsp_valid: pc <= target, drop <= 1, stay WAIT.
REQ-027 Redirect in WAIT with imem_rsp_valid same cycle: response discarded, drop <= 0, pc <= target, -> REQ.
REQ-028 Redirect in HOLD: out_valid low next cycle, pc <= target (not pc+STEP even if out_ready=1), -> REQ; a same-cycle out_valid&&out_ready handshake still counts as delivered.
REQ-029 out_valid SHALL be 1 only in HOLD; imem_req_valid only in REQ; at most one fetch outstanding.
REQ-030 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-031 rst=1 at a clock edge SHALL force state BOOT, pc=RESET_VAL, drop=0, out_pc=RESET_VAL, out_inst=0, out_valid=0, imem_req_valid=0, imem_req_addr=RESET_VAL, regardless of state or in-flight fetch.
REQ-032 rst SHALL take priority over every redirect and handshake input.
REQ-033 A response arriving after a mid-WAIT reset SHALL be ignored (state BOOT/REQ).

Verification
REQ-034 Reset release, ready memory with 1-cycle latency, out_ready=1 -> first req at cycle 2 addr 0x8000_0000, out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc, out_inst held constant; no new imem request.
REQ-036 redirect_valid=1, redirect_pc=0x8000_0100 in WAIT -> in-flight response discarded, next req addr 0x8000_0100, next out_pc 0x8000_0100.
REQ-037 trap_valid and redirect_valid same cycle, trap_pc=0x8000_0200, redirect_pc=0x8000_0300 -> next req addr 0x8000_0200.
REQ-038 XLEN=32, pc=0xFFFF_FFFC, handshake -> next req addr 0x0000_0000; redirect_pc=0x8000_0103 -> req addr 0x8000_0100.
REQ-039 rst asserted in WAIT, response arrives next cycle -> out_valid stays 0, first post-reset req addr 0x8000_0000.
